// File: rtl/mc_pkg.sv
// Shared constants for the multi-cycle control FSM: opcode and funct values,
// the 4-bit state encoding, datapath select codes, ALU op codes and the
// decoded control bundle. The package has no ports.
package mc_pkg;

  // Opcodes (instr[15:13])
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SLI  = 3'b001;
  localparam logic [2:0] OP_J    = 3'b010;
  localparam logic [2:0] OP_JAL  = 3'b011;
  localparam logic [2:0] OP_LW   = 3'b100;
  localparam logic [2:0] OP_SW   = 3'b101;
  localparam logic [2:0] OP_BEQ  = 3'b110;
  localparam logic [2:0] OP_ADDI = 3'b111;

  localparam logic [3:0] FUNCT_JR = 4'b1000;

  // FSM state encoding
  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_EXEC_R    = 4'd2;
  localparam logic [3:0] S_WB_R      = 4'd3;
  localparam logic [3:0] S_EXEC_SLI  = 4'd4;
  localparam logic [3:0] S_EXEC_ADDI = 4'd5;
  localparam logic [3:0] S_WB_I      = 4'd6;
  localparam logic [3:0] S_MEM_ADDR  = 4'd7;
  localparam logic [3:0] S_MEM_RD    = 4'd8;
  localparam logic [3:0] S_MEM_WB    = 4'd9;
  localparam logic [3:0] S_MEM_WR    = 4'd10;
  localparam logic [3:0] S_BRANCH    = 4'd11;
  localparam logic [3:0] S_JUMP      = 4'd12;
  localparam logic [3:0] S_JAL       = 4'd13;
  localparam logic [3:0] S_JR        = 4'd14;
  localparam logic [3:0] S_FAULT     = 4'd15;

  // PC source select
  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
  localparam logic [1:0] PC_SRC_REGA   = 2'b11;

  // ALU B operand select
  localparam logic [1:0] ALU_B_REGB   = 2'b00;
  localparam logic [1:0] ALU_B_TWO    = 2'b01;
  localparam logic [1:0] ALU_B_IMM    = 2'b10;
  localparam logic [1:0] ALU_B_IMM_SH = 2'b11;

  // Register destination select
  localparam logic [1:0] REG_DST_A  = 2'b00;  // instr[9:7]
  localparam logic [1:0] REG_DST_B  = 2'b01;  // instr[6:4]
  localparam logic [1:0] REG_DST_R7 = 2'b10;

  // Register write-back source select
  localparam logic [1:0] WB_SRC_ALUOUT = 2'b00;
  localparam logic [1:0] WB_SRC_MDR    = 2'b01;
  localparam logic [1:0] WB_SRC_PC     = 2'b10;

  // ALU op codes, shared with the single-cycle core
  localparam logic [1:0] ALU_OP_DFLT = 2'b00;
  localparam logic [1:0] ALU_OP_BEQ  = 2'b01;
  localparam logic [1:0] ALU_OP_SLI  = 2'b10;
  localparam logic [1:0] ALU_OP_ADDI = 2'b11;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       sign_or_zero;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       retire;
    logic       fault;
  } ctrl_t;

  // Quiescent control word: no strobes, sign extension selected.
  function automatic ctrl_t ctrl_idle();
    ctrl_t c;
    c              = '0;
    c.sign_or_zero = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive memory request cycles without an acknowledge and flags
// the cycle in which the wait limit would be reached.
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   req_i       memory request currently asserted
//   ack_i       memory acknowledges this cycle
//   expire_o    this un-acked request cycle is the MEM_TIMEOUT-th one
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic req_i,
  input  logic ack_i,
  output logic expire_o
);

  if (MEM_TIMEOUT == 0) begin : g_off
    logic unused_inputs;
    assign unused_inputs = clk ^ reset ^ req_i ^ ack_i;
    assign expire_o      = 1'b0;
  end else begin : g_on
    localparam int unsigned CntW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    logic [CntW-1:0] cnt_q, cnt_d;

    // Expire combinationally so the FSM leaves on the same edge that would
    // have made the count equal MEM_TIMEOUT.
    assign expire_o = req_i && !ack_i && (cnt_q == CntW'(MEM_TIMEOUT - 1));

    always_comb begin
      cnt_d = cnt_q;
      if (!req_i || ack_i || expire_o) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for the 16-bit MIPS-style core. Sequences each
// instruction through fetch/decode/execute/memory/write-back, drives a
// req/ack memory handshake, counts retired instructions and latches a fault
// when a memory request waits too long.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   opcode, funct     instruction fields from the IR
//   zero              ALU zero flag (qualifies pc_write_cond in the datapath)
//   mem_ack           memory completes the current request
//   mem_req..state    datapath controls, retire pulse, counter, fault, state
module multicycle_control
  import mc_pkg::*;
#(
  parameter int unsigned OPCODE_W    = 3,
  parameter int unsigned FUNCT_W     = 4,
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [FUNCT_W-1:0]  funct,
  input  logic                zero,
  input  logic                mem_ack,
  output logic                mem_req,
  output logic                mem_we,
  output logic                iord,
  output logic                ir_write,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic [1:0]          pc_source,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic                sign_or_zero,
  output logic                reg_write,
  output logic [1:0]          reg_dst,
  output logic [1:0]          mem_to_reg,
  output logic                retire,
  output logic [CNT_W-1:0]    instr_count,
  output logic                fault,
  output logic [3:0]          state
);

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  // High for the cycle following a reset edge: strobes stay low so no
  // request is issued while the rest of the core is still coming out of reset.
  logic             boot_q;
  logic             expire;
  ctrl_t            ctrl;

  // The branch decision is made in the datapath from pc_write_cond & zero.
  logic unused_inputs;
  assign unused_inputs = zero;

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .req_i   (ctrl.mem_req),
    .ack_i   (mem_ack),
    .expire_o(expire)
  );

  always_comb begin
    state_d = state_q;
    if (!boot_q) begin
      case (state_q)
        S_FETCH: begin
          if (expire)       state_d = S_FAULT;
          else if (mem_ack) state_d = S_DECODE;
        end
        S_DECODE: begin
          case (opcode)
            OPCODE_W'(OP_ADD):  state_d = (funct == FUNCT_W'(FUNCT_JR)) ? S_JR : S_EXEC_R;
            OPCODE_W'(OP_SLI):  state_d = S_EXEC_SLI;
            OPCODE_W'(OP_J):    state_d = S_JUMP;
            OPCODE_W'(OP_JAL):  state_d = S_JAL;
            OPCODE_W'(OP_LW),
            OPCODE_W'(OP_SW):   state_d = S_MEM_ADDR;
            OPCODE_W'(OP_BEQ):  state_d = S_BRANCH;
            OPCODE_W'(OP_ADDI): state_d = S_EXEC_ADDI;
            default:            state_d = S_FETCH;
          endcase
        end
        S_EXEC_R:    state_d = S_WB_R;
        S_EXEC_SLI,
        S_EXEC_ADDI: state_d = S_WB_I;
        S_MEM_ADDR:  state_d = (opcode == OPCODE_W'(OP_LW)) ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD: begin
          if (expire)       state_d = S_FAULT;
          else if (mem_ack) state_d = S_MEM_WB;
        end
        S_MEM_WR: begin
          if (expire)       state_d = S_FAULT;
          else if (mem_ack) state_d = S_FETCH;
        end
        S_WB_R, S_WB_I, S_MEM_WB, S_BRANCH, S_JUMP, S_JAL, S_JR: state_d = S_FETCH;
        S_FAULT:     state_d = S_FAULT;
        default:     state_d = S_FETCH;
      endcase
    end
  end

  always_comb begin
    ctrl = ctrl_idle();
    case (state_q)
      S_FETCH: begin
        ctrl.mem_req   = 1'b1;
        ctrl.alu_src_b = ALU_B_TWO;
        ctrl.ir_write  = mem_ack;
        ctrl.pc_write  = mem_ack;
      end
      S_DECODE: begin
        ctrl.alu_src_b = ALU_B_IMM_SH;
        ctrl.alu_op    = ALU_OP_ADDI;
      end
      S_EXEC_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALU_B_REGB;
        ctrl.alu_op    = ALU_OP_DFLT;
      end
      S_WB_R: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = REG_DST_B;
        ctrl.mem_to_reg = WB_SRC_ALUOUT;
        ctrl.retire     = 1'b1;
      end
      S_EXEC_SLI: begin
        ctrl.alu_src_b    = ALU_B_IMM;
        ctrl.alu_op       = ALU_OP_SLI;
        ctrl.sign_or_zero = 1'b0;
      end
      S_EXEC_ADDI: begin
        ctrl.alu_src_b = ALU_B_IMM;
        ctrl.alu_op    = ALU_OP_ADDI;
      end
      S_WB_I: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = REG_DST_A;
        ctrl.retire    = 1'b1;
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALU_B_IMM;
        ctrl.alu_op    = ALU_OP_ADDI;
      end
      S_MEM_RD: begin
        ctrl.mem_req = 1'b1;
        ctrl.iord    = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = WB_SRC_MDR;
        ctrl.reg_dst    = REG_DST_A;
        ctrl.retire     = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.mem_req = 1'b1;
        ctrl.mem_we  = 1'b1;
        ctrl.iord    = 1'b1;
        ctrl.retire  = mem_ack;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = ALU_B_REGB;
        ctrl.alu_op        = ALU_OP_BEQ;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PC_SRC_ALUOUT;
        ctrl.retire        = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PC_SRC_JUMP;
        ctrl.retire    = 1'b1;
      end
      S_JAL: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PC_SRC_JUMP;
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = REG_DST_R7;
        ctrl.mem_to_reg = WB_SRC_PC;
        ctrl.retire     = 1'b1;
      end
      S_JR: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PC_SRC_REGA;
        ctrl.retire    = 1'b1;
      end
      S_FAULT: begin
        ctrl.fault = 1'b1;
      end
      default: ctrl = ctrl_idle();
    endcase

    if (boot_q) begin
      ctrl.mem_req       = 1'b0;
      ctrl.mem_we        = 1'b0;
      ctrl.ir_write      = 1'b0;
      ctrl.pc_write      = 1'b0;
      ctrl.pc_write_cond = 1'b0;
      ctrl.reg_write     = 1'b0;
      ctrl.retire        = 1'b0;
    end
  end

  assign count_d = count_q + CNT_W'(ctrl.retire);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      count_q <= '0;
      boot_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      boot_q  <= 1'b0;
    end
  end

  assign mem_req       = ctrl.mem_req;
  assign mem_we        = ctrl.mem_we;
  assign iord          = ctrl.iord;
  assign ir_write      = ctrl.ir_write;
  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign pc_source     = ctrl.pc_source;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign sign_or_zero  = ctrl.sign_or_zero;
  assign reg_write     = ctrl.reg_write;
  assign reg_dst       = ctrl.reg_dst;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign retire        = ctrl.retire;
  assign instr_count   = count_q;
  assign fault         = ctrl.fault;
  assign state         = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: an instruction-recipe reference model
// compared every cycle, plus directed literal checks of key scenarios.
module tb_multicycle_control;
  import mc_pkg::*;

  localparam int unsigned TMO = 4;
  localparam int unsigned CW  = 4;

  logic          clk = 1'b0;
  logic          reset, zero, mem_ack;
  logic [2:0]    opcode;
  logic [3:0]    funct;
  logic          mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond;
  logic [1:0]    pc_source, alu_src_b, alu_op, reg_dst, mem_to_reg;
  logic          alu_src_a, sign_or_zero, reg_write, retire, fault;
  logic [CW-1:0] instr_count;
  logic [3:0]    state;

  always #5 clk = ~clk;

  multicycle_control #(
    .OPCODE_W(3), .FUNCT_W(4), .MEM_TIMEOUT(TMO), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .pc_source(pc_source), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .sign_or_zero(sign_or_zero), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .retire(retire),
    .instr_count(instr_count), .fault(fault), .state(state)
  );

  wire [24:0] act_vec = {mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, pc_source,
                         alu_src_a, alu_src_b, alu_op, sign_or_zero, reg_write, reg_dst,
                         mem_to_reg, retire, fault, state};

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: current step, remaining steps of the instruction recipe.
  bit         m_boot, m_fault;
  logic [3:0] m_stage;
  logic [3:0] m_rest[$];
  int         m_waits, m_count;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_mem(input logic [3:0] s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

  function automatic bit m_last();
    return !m_fault && m_stage != S_FETCH && m_stage != S_DECODE && m_rest.size() == 0;
  endfunction

  task automatic build_recipe(input logic [2:0] opc, input logic [3:0] fn);
    m_rest.delete();
    case (opc)
      3'd0: if (fn == 4'b1000) m_rest.push_back(S_JR);
            else begin m_rest.push_back(S_EXEC_R); m_rest.push_back(S_WB_R); end
      3'd1: begin m_rest.push_back(S_EXEC_SLI); m_rest.push_back(S_WB_I); end
      3'd2: m_rest.push_back(S_JUMP);
      3'd3: m_rest.push_back(S_JAL);
      3'd4: begin m_rest.push_back(S_MEM_ADDR); m_rest.push_back(S_MEM_RD);
                  m_rest.push_back(S_MEM_WB); end
      3'd5: begin m_rest.push_back(S_MEM_ADDR); m_rest.push_back(S_MEM_WR); end
      3'd6: m_rest.push_back(S_BRANCH);
      default: begin m_rest.push_back(S_EXEC_ADDI); m_rest.push_back(S_WB_I); end
    endcase
  endtask

  function automatic logic [24:0] exp_vec();
    logic req, we, io, irw, pcw, pcwc, a, soz, rw, ret;
    logic [1:0] psrc, b, op, rd, m2r;
    req = 0; we = 0; io = 0; irw = 0; pcw = 0; pcwc = 0; a = 0; soz = 1; rw = 0; ret = 0;
    psrc = 2'b00; b = 2'b00; op = 2'b00; rd = 2'b00; m2r = 2'b00;
    if (!m_fault) begin
      case (m_stage)
        S_FETCH:     begin req = 1; b = 2'b01; irw = mem_ack; pcw = mem_ack; end
        S_DECODE:    begin b = 2'b11; op = 2'b11; end
        S_EXEC_R:    begin a = 1; end
        S_WB_R:      begin rw = 1; rd = 2'b01; end
        S_EXEC_SLI:  begin b = 2'b10; op = 2'b10; soz = 0; end
        S_EXEC_ADDI: begin b = 2'b10; op = 2'b11; end
        S_WB_I:      begin rw = 1; end
        S_MEM_ADDR:  begin a = 1; b = 2'b10; op = 2'b11; end
        S_MEM_RD:    begin req = 1; io = 1; end
        S_MEM_WB:    begin rw = 1; m2r = 2'b01; end
        S_MEM_WR:    begin req = 1; we = 1; io = 1; end
        S_BRANCH:    begin a = 1; op = 2'b01; pcwc = 1; psrc = 2'b01; end
        S_JUMP:      begin pcw = 1; psrc = 2'b10; end
        S_JAL:       begin pcw = 1; psrc = 2'b10; rw = 1; rd = 2'b10; m2r = 2'b10; end
        S_JR:        begin pcw = 1; psrc = 2'b11; end
        default:     ;
      endcase
      ret = m_last() && (!is_mem(m_stage) || mem_ack);
    end
    if (m_boot) begin
      req = 0; we = 0; irw = 0; pcw = 0; pcwc = 0; rw = 0; ret = 0;
    end
    return {req, we, io, irw, pcw, pcwc, psrc, a, b, op, soz, rw, rd, m2r, ret, m_fault,
            m_fault ? S_FAULT : m_stage};
  endfunction

  task automatic model_update();
    if (reset) begin
      m_boot = 1; m_fault = 0; m_stage = S_FETCH; m_rest.delete(); m_waits = 0; m_count = 0;
    end else if (m_boot) begin
      m_boot = 0;
    end else if (!m_fault) begin
      if (is_mem(m_stage) && !mem_ack) begin
        m_waits++;
        if (m_waits == TMO) m_fault = 1;
      end else begin
        m_waits = 0;
        if (m_last()) begin
          m_count = (m_count + 1) % (1 << CW);
          m_stage = S_FETCH;
        end else if (m_stage == S_FETCH) begin
          m_stage = S_DECODE;
        end else begin
          if (m_stage == S_DECODE) build_recipe(opcode, funct);
          m_stage = m_rest.pop_front();
        end
      end
    end
  endtask

  task automatic sample(input logic rst, input logic ack, input logic z,
                        input logic [2:0] opc, input logic [3:0] fn);
    @(negedge clk);
    reset = rst; mem_ack = ack; zero = z; opcode = opc; funct = fn;
    #1;
    check("outputs", {7'b0, act_vec}, {7'b0, exp_vec()});
    check("instr_count", 32'(instr_count), 32'(m_count));
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
  endtask

  initial begin
    logic [3:0] add_seq[4];
    add_seq[0] = S_FETCH; add_seq[1] = S_DECODE; add_seq[2] = S_EXEC_R; add_seq[3] = S_WB_R;
    reset = 1; mem_ack = 0; zero = 0; opcode = 3'd0; funct = 4'd0;
    m_boot = 0; m_fault = 0; m_stage = S_FETCH; m_waits = 0; m_count = 0;
    tick();

    // Cycle after the reset edge: quiet outputs.
    sample(0, 1, 0, 3'd0, 4'd0);
    check("rst_mem_req", 32'(mem_req), 0);
    check("rst_count", 32'(instr_count), 0);
    check("rst_fault", 32'(fault), 0);
    check("rst_soz", 32'(sign_or_zero), 1);
    check("rst_state", 32'(state), 32'(S_FETCH));
    tick();

    // add, ack tied high: four cycles, retire in the fourth.
    for (int c = 1; c <= 4; c++) begin
      sample(0, 1, 0, 3'd0, 4'd0);
      check("add_state", 32'(state), 32'(add_seq[c-1]));
      if (c == 4) check("add_retire", 32'(retire), 1);
      tick();
    end

    // lw, ack withheld for three MEM_RD cycles: MEM_WB in cycle 8.
    for (int c = 1; c <= 8; c++) begin
      sample(0, (c >= 4 && c <= 6) ? 1'b0 : 1'b1, 0, 3'd4, 4'd5);
      if (c == 1) check("add_count", 32'(instr_count), 1);
      if (c >= 4 && c <= 7) check("lw_mem_req", 32'(mem_req), 1);
      if (c == 8) begin
        check("lw_state", 32'(state), 32'(S_MEM_WB));
        check("lw_reg_write", 32'(reg_write), 1);
        check("lw_mem_to_reg", 32'(mem_to_reg), 32'h1);
      end
      tick();
    end

    // beq taken then not taken: same controls, three cycles each.
    for (int k = 0; k < 2; k++) begin
      for (int c = 1; c <= 3; c++) begin
        sample(0, 1, (k == 0), 3'd6, 4'd0);
        if (c == 3) begin
          check("beq_state", 32'(state), 32'(S_BRANCH));
          check("beq_pcwc", 32'(pc_write_cond), 1);
          check("beq_pcsrc", 32'(pc_source), 32'h1);
          check("beq_retire", 32'(retire), 1);
        end
        tick();
      end
    end

    // jr then jal.
    for (int c = 1; c <= 3; c++) begin
      sample(0, 1, 0, 3'd0, 4'b1000);
      if (c == 3) begin
        check("jr_state", 32'(state), 32'(S_JR));
        check("jr_pcsrc", 32'(pc_source), 32'h3);
        check("jr_reg_write", 32'(reg_write), 0);
      end
      tick();
    end
    for (int c = 1; c <= 3; c++) begin
      sample(0, 1, 0, 3'd3, 4'd0);
      if (c == 3) begin
        check("jal_reg_dst", 32'(reg_dst), 32'h2);
        check("jal_mem_to_reg", 32'(mem_to_reg), 32'h2);
      end
      tick();
    end

    // sw with reset landing during the MEM_WR wait.
    for (int c = 1; c <= 5; c++) begin
      sample(c == 5, c < 4, 0, 3'd5, 4'd0);
      if (c == 4) check("sw_mem_we", 32'(mem_we), 1);
      tick();
    end
    sample(0, 0, 0, 3'd5, 4'd0);
    check("rstwr_state", 32'(state), 32'(S_FETCH));
    check("rstwr_mem_we", 32'(mem_we), 0);
    check("rstwr_mem_req", 32'(mem_req), 0);
    check("rstwr_count", 32'(instr_count), 0);
    tick();

    // Fetch never acked: FAULT after TMO request cycles, sticky until reset.
    for (int c = 1; c <= 6; c++) begin
      sample(0, c == 6, 0, 3'd0, 4'd0);
      if (c <= 4) check("tmo_mem_req", 32'(mem_req), 1);
      if (c >= 5) begin
        check("tmo_state", 32'(state), 32'(S_FAULT));
        check("tmo_fault", 32'(fault), 1);
        check("tmo_mem_req_low", 32'(mem_req), 0);
      end
      tick();
    end
    sample(1, 0, 0, 3'd0, 4'd0);
    tick();
    sample(0, 0, 0, 3'd0, 4'd0);
    check("clr_state", 32'(state), 32'(S_FETCH));
    check("clr_fault", 32'(fault), 0);
    tick();

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      logic       rst, ack, z;
      logic [2:0] opc;
      logic [3:0] fn;
      rst = ($urandom_range(0, 299) == 0) || (m_fault && $urandom_range(0, 3) == 0);
      if (is_mem(m_stage) && !m_boot && !m_fault && m_waits == TMO - 1)
        ack = ($urandom_range(0, 19) != 0);
      else
        ack = 1'($urandom_range(0, 1));
      z = 1'($urandom_range(0, 1));
      if (m_boot || m_fault || m_stage == S_FETCH) begin
        opc = 3'($urandom_range(0, 7));
        fn  = ($urandom_range(0, 2) == 0) ? 4'b1000 : 4'($urandom_range(0, 15));
      end else begin
        opc = opcode;
        fn  = funct;
      end
      sample(rst, ack, z, opc, fn);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
